// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared types and constants for the data-memory access controller
package dm_pkg;

  localparam int DM_ADD_W = 16;
  localparam int DM_DT_W  = 16;
  localparam int CNT_W    = 8;

  localparam logic [DM_ADD_W-1:0] DM_SIZE_DEF = 16'h4000;
  localparam int                  TIMEOUT_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } dm_state_e;

endpackage

// File: rtl/dm_access_ctrl_if.sv
// rtl/dm_access_ctrl_if.sv - sequencer, DAG, bus-connect and memory signals of the DM controller
interface dm_access_ctrl_if;
  import dm_pkg::*;

  logic                ps_dm_en;
  logic                ps_dm_wrt_en;
  logic                ps_dm_err_clr;
  logic [DM_ADD_W-1:0] dg_dm_add;
  logic [DM_DT_W-1:0]  bc_dt_out;
  logic                dm_ps_stall;
  logic                dm_ps_err;
  logic [DM_DT_W-1:0]  dm_bc_dt;
  logic                dm_bc_dt_vld;
  logic                dm_mem_req;
  logic                dm_mem_we;
  logic [DM_ADD_W-1:0] dm_mem_add;
  logic [DM_DT_W-1:0]  dm_mem_wdt;
  logic                mem_dm_ack;
  logic [DM_DT_W-1:0]  mem_dm_rdt;

  modport master (
    input  ps_dm_en, ps_dm_wrt_en, ps_dm_err_clr, dg_dm_add, bc_dt_out,
    input  mem_dm_ack, mem_dm_rdt,
    output dm_ps_stall, dm_ps_err, dm_bc_dt, dm_bc_dt_vld,
    output dm_mem_req, dm_mem_we, dm_mem_add, dm_mem_wdt
  );

  modport slave (
    output ps_dm_en, ps_dm_wrt_en, ps_dm_err_clr, dg_dm_add, bc_dt_out,
    output mem_dm_ack, mem_dm_rdt,
    input  dm_ps_stall, dm_ps_err, dm_bc_dt, dm_bc_dt_vld,
    input  dm_mem_req, dm_mem_we, dm_mem_add, dm_mem_wdt
  );

endinterface

// File: rtl/dm_timeout_cnt.sv
// rtl/dm_timeout_cnt.sv - saturating 8-bit busy-cycle counter with terminal-count pulse
module dm_timeout_cnt
  import dm_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Pulses during the last permitted busy cycle so the abort lands on its closing edge.
  assign tc_o = en_i && (cnt_q == TC_VAL);

endmodule

// File: rtl/dm_access_ctrl.sv
// rtl/dm_access_ctrl.sv - single-outstanding DM access FSM with range check, timeout and sticky error
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter logic [DM_ADD_W-1:0] DM_SIZE = DM_SIZE_DEF,
  parameter int                  TIMEOUT = TIMEOUT_DEF
) (
  input logic               clk,
  input logic               rst_n,
  dm_access_ctrl_if.master  bus
);

  dm_state_e           state_q, state_d;
  logic                we_q, we_d;
  logic [DM_ADD_W-1:0] add_q, add_d;
  logic [DM_DT_W-1:0]  wdt_q, wdt_d;
  logic [DM_DT_W-1:0]  dt_q, dt_d;
  logic                vld_q, vld_d;
  logic                err_q, err_d;
  logic                err_set;
  logic                cnt_clr;
  logic                cnt_tc;

  dm_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .en_i  (state_q == BUSY),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    add_d   = add_q;
    wdt_d   = wdt_q;
    dt_d    = dt_q;
    vld_d   = 1'b0;
    err_set = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (bus.ps_dm_en) begin
          if (bus.dg_dm_add < DM_SIZE) begin
            we_d    = bus.ps_dm_wrt_en;
            add_d   = bus.dg_dm_add;
            wdt_d   = bus.bc_dt_out;
            state_d = BUSY;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      BUSY: begin
        // Requests arriving here are sequencer protocol violations and are dropped.
        // An ack coinciding with terminal count still completes the access.
        if (bus.mem_dm_ack) begin
          state_d = IDLE;
          if (!we_q) begin
            dt_d  = bus.mem_dm_rdt;
            vld_d = 1'b1;
          end
        end else if (cnt_tc) begin
          state_d = IDLE;
          err_set = 1'b1;
        end
      end
    endcase
    err_d = err_set || (err_q && !bus.ps_dm_err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      add_q   <= '0;
      wdt_q   <= '0;
      dt_q    <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      add_q   <= add_d;
      wdt_q   <= wdt_d;
      dt_q    <= dt_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign bus.dm_ps_stall  = (state_q == BUSY);
  assign bus.dm_mem_req   = (state_q == BUSY);
  assign bus.dm_ps_err    = err_q;
  assign bus.dm_bc_dt     = dt_q;
  assign bus.dm_bc_dt_vld = vld_q;
  assign bus.dm_mem_we    = we_q;
  assign bus.dm_mem_add   = add_q;
  assign bus.dm_mem_wdt   = wdt_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb/tb_dm_access_ctrl.sv - directed self-checking bench for dm_access_ctrl
module tb_dm_access_ctrl;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  dm_access_ctrl_if bus ();

  dm_access_ctrl #(
    .DM_SIZE (16'h4000),
    .TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic we, input logic [15:0] add, input logic [15:0] wdt);
    bus.ps_dm_en     = 1'b1;
    bus.ps_dm_wrt_en = we;
    bus.dg_dm_add    = add;
    bus.bc_dt_out    = wdt;
    tick();
    bus.ps_dm_en     = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, 32'(bus.dm_ps_stall), 32'h0);
    check({tag, "_err"},   32'(bus.dm_ps_err), 32'h0);
    check({tag, "_dt"},    32'(bus.dm_bc_dt), 32'h0);
    check({tag, "_vld"},   32'(bus.dm_bc_dt_vld), 32'h0);
    check({tag, "_req"},   32'(bus.dm_mem_req), 32'h0);
    check({tag, "_we"},    32'(bus.dm_mem_we), 32'h0);
    check({tag, "_add"},   32'(bus.dm_mem_add), 32'h0);
    check({tag, "_wdt"},   32'(bus.dm_mem_wdt), 32'h0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.ps_dm_en      = 1'b0;
    bus.ps_dm_wrt_en  = 1'b0;
    bus.ps_dm_err_clr = 1'b0;
    bus.dg_dm_add     = 16'h0;
    bus.bc_dt_out     = 16'h0;
    bus.mem_dm_ack    = 1'b0;
    bus.mem_dm_rdt    = 16'h0;
    tick();
    tick();
    check_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Load with ack in the first busy cycle
    request(1'b0, 16'h0010, 16'h0);
    check("ld1_req", 32'(bus.dm_mem_req), 32'h1);
    check("ld1_stall", 32'(bus.dm_ps_stall), 32'h1);
    check("ld1_add", 32'(bus.dm_mem_add), 32'h0010);
    check("ld1_we", 32'(bus.dm_mem_we), 32'h0);
    bus.mem_dm_ack = 1'b1;
    bus.mem_dm_rdt = 16'hBEEF;
    tick();
    bus.mem_dm_ack = 1'b0;
    bus.mem_dm_rdt = 16'h0;
    check("ld1_vld", 32'(bus.dm_bc_dt_vld), 32'h1);
    check("ld1_dt", 32'(bus.dm_bc_dt), 32'hBEEF);
    check("ld1_stall_off", 32'(bus.dm_ps_stall), 32'h0);
    check("ld1_req_off", 32'(bus.dm_mem_req), 32'h0);
    tick();
    check("ld1_vld_off", 32'(bus.dm_bc_dt_vld), 32'h0);

    // Store acked after three wait cycles; DAG/bus inputs change underneath
    request(1'b1, 16'h0020, 16'h1234);
    bus.dg_dm_add = 16'h7777;
    bus.bc_dt_out = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("st_stall%0d", i), 32'(bus.dm_ps_stall), 32'h1);
      check($sformatf("st_req%0d", i), 32'(bus.dm_mem_req), 32'h1);
      check($sformatf("st_we%0d", i), 32'(bus.dm_mem_we), 32'h1);
      check($sformatf("st_add%0d", i), 32'(bus.dm_mem_add), 32'h0020);
      check($sformatf("st_wdt%0d", i), 32'(bus.dm_mem_wdt), 32'h1234);
      check($sformatf("st_vld%0d", i), 32'(bus.dm_bc_dt_vld), 32'h0);
      if (i == 3) bus.mem_dm_ack = 1'b1;
      tick();
    end
    bus.mem_dm_ack = 1'b0;
    check("st_stall_off", 32'(bus.dm_ps_stall), 32'h0);
    check("st_vld", 32'(bus.dm_bc_dt_vld), 32'h0);
    check("st_dt_keep", 32'(bus.dm_bc_dt), 32'hBEEF);

    // Out-of-range at exactly DM_SIZE, then clear, then set+clear together
    request(1'b0, 16'h4000, 16'h0);
    check("oor_req", 32'(bus.dm_mem_req), 32'h0);
    check("oor_stall", 32'(bus.dm_ps_stall), 32'h0);
    check("oor_err", 32'(bus.dm_ps_err), 32'h1);
    check("oor_vld", 32'(bus.dm_bc_dt_vld), 32'h0);
    bus.ps_dm_err_clr = 1'b1;
    tick();
    bus.ps_dm_err_clr = 1'b0;
    check("clr_err", 32'(bus.dm_ps_err), 32'h0);
    bus.ps_dm_err_clr = 1'b1;
    request(1'b0, 16'hFFFF, 16'h0);
    bus.ps_dm_err_clr = 1'b0;
    check("setclr_err", 32'(bus.dm_ps_err), 32'h1);
    check("setclr_req", 32'(bus.dm_mem_req), 32'h0);
    bus.ps_dm_err_clr = 1'b1;
    tick();
    bus.ps_dm_err_clr = 1'b0;
    check("clr2_err", 32'(bus.dm_ps_err), 32'h0);

    // Highest legal address is accepted
    request(1'b0, 16'h3FFF, 16'h0);
    check("edge_req", 32'(bus.dm_mem_req), 32'h1);
    check("edge_add", 32'(bus.dm_mem_add), 32'h3FFF);
    bus.mem_dm_ack = 1'b1;
    bus.mem_dm_rdt = 16'hA5A5;
    tick();
    bus.mem_dm_ack = 1'b0;
    check("edge_dt", 32'(bus.dm_bc_dt), 32'hA5A5);
    check("edge_err", 32'(bus.dm_ps_err), 32'h0);

    // Timeout: no ack for TIMEOUT=16 busy cycles
    request(1'b0, 16'h0030, 16'h0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("to_req%0d", i), 32'(bus.dm_mem_req), 32'h1);
      check($sformatf("to_stall%0d", i), 32'(bus.dm_ps_stall), 32'h1);
      check($sformatf("to_err%0d", i), 32'(bus.dm_ps_err), 32'h0);
      check($sformatf("to_vld%0d", i), 32'(bus.dm_bc_dt_vld), 32'h0);
      tick();
    end
    check("to_stall_off", 32'(bus.dm_ps_stall), 32'h0);
    check("to_req_off", 32'(bus.dm_mem_req), 32'h0);
    check("to_err", 32'(bus.dm_ps_err), 32'h1);
    check("to_dt_keep", 32'(bus.dm_bc_dt), 32'hA5A5);
    check("to_vld", 32'(bus.dm_bc_dt_vld), 32'h0);
    bus.ps_dm_err_clr = 1'b1;
    tick();
    bus.ps_dm_err_clr = 1'b0;

    // Back-to-back loads, with an ignored request while busy
    request(1'b0, 16'h0040, 16'h0);
    bus.mem_dm_ack = 1'b1;
    bus.mem_dm_rdt = 16'h1111;
    tick();
    bus.mem_dm_ack = 1'b0;
    check("b2b1_vld", 32'(bus.dm_bc_dt_vld), 32'h1);
    check("b2b1_dt", 32'(bus.dm_bc_dt), 32'h1111);
    request(1'b0, 16'h0041, 16'h0);
    check("b2b2_stall", 32'(bus.dm_ps_stall), 32'h1);
    check("b2b2_add", 32'(bus.dm_mem_add), 32'h0041);
    check("b2b2_vld_off", 32'(bus.dm_bc_dt_vld), 32'h0);
    request(1'b1, 16'h5000, 16'h9999);
    check("viol_add", 32'(bus.dm_mem_add), 32'h0041);
    check("viol_we", 32'(bus.dm_mem_we), 32'h0);
    check("viol_err", 32'(bus.dm_ps_err), 32'h0);
    check("viol_stall", 32'(bus.dm_ps_stall), 32'h1);
    bus.mem_dm_ack = 1'b1;
    bus.mem_dm_rdt = 16'h2222;
    tick();
    bus.mem_dm_ack = 1'b0;
    check("b2b2_vld", 32'(bus.dm_bc_dt_vld), 32'h1);
    check("b2b2_dt", 32'(bus.dm_bc_dt), 32'h2222);
    check("b2b2_err", 32'(bus.dm_ps_err), 32'h0);

    // Asynchronous reset in the middle of a busy access
    request(1'b1, 16'h0060, 16'hCAFE);
    check("rb_stall", 32'(bus.dm_ps_stall), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("arst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    request(1'b0, 16'h0070, 16'h0);
    check("post_req", 32'(bus.dm_mem_req), 32'h1);
    check("post_add", 32'(bus.dm_mem_add), 32'h0070);
    bus.mem_dm_ack = 1'b1;
    bus.mem_dm_rdt = 16'h3333;
    tick();
    bus.mem_dm_ack = 1'b0;
    check("post_vld", 32'(bus.dm_bc_dt_vld), 32'h1);
    check("post_dt", 32'(bus.dm_bc_dt), 32'h3333);
    check("post_stall", 32'(bus.dm_ps_stall), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
